// File: rtl/f3x_mult_sched.sv
// f3x_mult_sched: controller for multiplication in GF(Q^3) = GF(Q)[y]/(y^3 - y - 1).
// It runs a 6-product Karatsuba schedule through one shared external base-field
// multiplier, using a req/ack handshake. Operands and the result use
// valid/ready handshakes.
// Trits are 2-bit codes: 00=0, 01=1, 10=2.
module f3x_mult_sched #(
    parameter int WB = 388
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_sq,
    input  logic [3*WB-1:0] in_a,
    input  logic [3*WB-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3*WB-1:0] out_c,
    output logic            busy,
    output logic            mul_req,
    output logic [WB-1:0]   mul_a,
    output logic [WB-1:0]   mul_b,
    input  logic            mul_ack,
    input  logic [WB-1:0]   mul_c
);

    typedef enum logic [1:0] {IDLE, ISSUE, COMB, OUT} state_t;

    state_t            state_q;
    logic [2:0]        k_q;
    logic [3*WB-1:0]   a_q;
    logic [3*WB-1:0]   b_q;
    logic [WB-1:0]     x_q [0:5];
    logic              mul_req_q;
    logic [WB-1:0]     mul_a_q;
    logic [WB-1:0]     mul_b_q;
    logic [3*WB-1:0]   out_c_q;
    logic              out_valid_q;

    logic [2:0]        k_nxt;
    logic [WB-1:0]     op_a_nxt;
    logic [WB-1:0]     op_b_nxt;
    logic [3*WB-1:0]   acc_b;
    logic [WB-1:0]     d1, d2, d3, c0, c1, c2;
    logic [3*WB-1:0]   c_d;

    // Trit-wise addition mod 3.
    function automatic logic [WB-1:0] f3_add(input logic [WB-1:0] x, input logic [WB-1:0] y);
        logic [WB-1:0] r;
        logic [2:0]    s;
        r = '0;
        for (int unsigned i = 0; i < WB / 2; i++) begin
            s = {1'b0, x[2*i +: 2]} + {1'b0, y[2*i +: 2]};
            if (s >= 3'd3) s = s - 3'd3;
            r[2*i +: 2] = s[1:0];
        end
        return r;
    endfunction

    // Trit-wise negation: swapping the two code bits maps 1 <-> 2 and keeps 0.
    function automatic logic [WB-1:0] f3_neg(input logic [WB-1:0] x);
        logic [WB-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < WB / 2; i++) begin
            r[2*i +: 2] = {x[2*i], x[2*i+1]};
        end
        return r;
    endfunction

    function automatic logic [WB-1:0] f3_sub(input logic [WB-1:0] x, input logic [WB-1:0] y);
        return f3_add(x, f3_neg(y));
    endfunction

    // Operand for product k, taken from one packed {v2,v1,v0} extension element.
    function automatic logic [WB-1:0] opnd(input logic [2:0] k, input logic [3*WB-1:0] v);
        logic [WB-1:0] v0, v1, v2, r;
        v0 = v[WB-1:0];
        v1 = v[2*WB-1:WB];
        v2 = v[3*WB-1:2*WB];
        case (k)
            3'd0:    r = v2;
            3'd1:    r = f3_add(v2, v1);
            3'd2:    r = v1;
            3'd3:    r = f3_add(v2, v0);
            3'd4:    r = f3_add(v1, v0);
            3'd5:    r = v0;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Operands for the next product, and Karatsuba recombination with y^3 = y + 1 folded in.
    always_comb begin
        k_nxt    = k_q + 3'd1;
        op_a_nxt = opnd(k_nxt, a_q);
        op_b_nxt = opnd(k_nxt, b_q);
        acc_b    = in_sq ? in_a : in_b;
        d3       = f3_sub(f3_sub(x_q[1], x_q[0]), x_q[2]);
        d1       = f3_sub(f3_sub(x_q[4], x_q[2]), x_q[5]);
        d2       = f3_sub(f3_sub(f3_add(x_q[3], x_q[2]), x_q[0]), x_q[5]);
        c0       = f3_add(x_q[5], d3);
        c1       = f3_add(f3_add(d1, d3), x_q[0]);
        c2       = f3_add(d2, x_q[0]);
        c_d      = {c2, c1, c0};
    end

    // Control FSM with registered handshake and multiplier outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            x_q         <= '{default: '0};
            mul_req_q   <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            out_c_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q       <= in_a;
                        b_q       <= acc_b;
                        k_q       <= '0;
                        mul_a_q   <= opnd(3'd0, in_a);
                        mul_b_q   <= opnd(3'd0, acc_b);
                        mul_req_q <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mul_ack) begin
                        x_q[k_q] <= mul_c;
                        if (k_q == 3'd5) begin
                            mul_req_q <= 1'b0;
                            state_q   <= COMB;
                        end else begin
                            k_q     <= k_nxt;
                            mul_a_q <= op_a_nxt;
                            mul_b_q <= op_b_nxt;
                        end
                    end
                end
                COMB: begin
                    out_c_q     <= c_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) & reset;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_c     = out_c_q;
    assign mul_req   = mul_req_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_f3x_mult_sched.sv
// Directed bench for f3x_mult_sched at WB=4.
// The base field is GF(9) = GF(3)[z]/(z^2+1). In each base element, trit0 is the
// constant term and trit1 is the z coefficient.
module tb_f3x_mult_sched;

    localparam int WB = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic            in_sq;
    logic [3*WB-1:0] in_a;
    logic [3*WB-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [3*WB-1:0] out_c;
    logic            busy;
    logic            mul_req;
    logic [WB-1:0]   mul_a;
    logic [WB-1:0]   mul_b;
    logic            mul_ack;
    logic [WB-1:0]   mul_c;

    f3x_mult_sched #(.WB(WB)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sq     (in_sq),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .busy      (busy),
        .mul_req   (mul_req),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_ack   (mul_ack),
        .mul_c     (mul_c)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Responder controls, set by the main sequence.
    int            wait_cfg  = 0;
    bit            rnd_wait  = 1'b0;
    bit            stray_en  = 1'b0;
    bit            sq_chk    = 1'b0;
    int            ack_count = 0;
    int            req_cycles = 0;
    logic [WB-1:0] log_a [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // GF(9) product with z^2 = 2.
    function automatic logic [3:0] gmul9(input logic [3:0] x, input logic [3:0] y);
        int x0, x1, y0, y1, r0, r1;
        x0 = int'(x[1:0]);
        x1 = int'(x[3:2]);
        y0 = int'(y[1:0]);
        y1 = int'(y[3:2]);
        r0 = (x0 * y0 + 2 * x1 * y1) % 3;
        r1 = (x0 * y1 + x1 * y0) % 3;
        return {2'(r1), 2'(r0)};
    endfunction

    // External base multiplier: acknowledges each request after a chosen delay.
    // It also checks that the operands stay stable while the request is pending.
    initial begin : responder
        bit            pending;
        int            cnt;
        logic [WB-1:0] ref_a, ref_b;
        pending = 1'b0;
        cnt     = 0;
        ref_a   = '0;
        ref_b   = '0;
        mul_ack = 1'b0;
        mul_c   = '0;
        forever begin
            @(negedge clk);
            if (mul_req === 1'b1) begin
                req_cycles++;
                if (!pending) begin
                    pending = 1'b1;
                    ref_a   = mul_a;
                    ref_b   = mul_b;
                    cnt     = rnd_wait ? int'($urandom_range(0, 5)) : wait_cfg;
                    if (sq_chk) check("sq_mul_b_eq_mul_a", 64'(mul_b), 64'(mul_a));
                end else begin
                    check("hold_mul_a", 64'(mul_a), 64'(ref_a));
                    check("hold_mul_b", 64'(mul_b), 64'(ref_b));
                end
                if (cnt == 0) begin
                    mul_ack = 1'b1;
                    mul_c   = gmul9(mul_a, mul_b);
                    log_a.push_back(mul_a);
                    ack_count++;
                    pending = 1'b0;
                end else begin
                    cnt--;
                    mul_ack = 1'b0;
                    mul_c   = 4'($urandom);
                end
            end else begin
                pending = 1'b0;
                mul_ack = stray_en ? ($urandom_range(0, 1) != 0) : 1'b0;
                mul_c   = 4'($urandom);
            end
        end
    end

    // One transaction: accept, scramble inputs, wait for result, then optionally handshake.
    task automatic run_op(input logic [11:0] a, input logic [11:0] b, input logic sq,
                          input logic [11:0] exp, input string tag,
                          input int exp_lat, input int exp_req);
        int lat;
        @(negedge clk);
        in_valid   = 1'b1;
        in_a       = a;
        in_b       = b;
        in_sq      = sq;
        log_a.delete();
        req_cycles = 0;
        ack_count  = 0;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = 12'($urandom);
        in_b     = 12'($urandom);
        in_sq    = ~sq;
        lat      = 0;
        while (out_valid !== 1'b1 && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        if (exp_lat >= 0) check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_out_c"}, 64'(out_c), 64'(exp));
        if (exp_req >= 0) check({tag, "_req_cycles"}, 64'(req_cycles), 64'(exp_req));
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({tag, "_done_valid"}, 64'(out_valid), 64'd0);
            check({tag, "_done_ready"}, 64'(in_ready), 64'd1);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [3:0] exp_seq [6];
        int n;
        exp_seq = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sq     = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        #2 reset  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_mul_req",   64'(mul_req),   64'd0);
        check("rst_out_c",     64'(out_c),     64'd0);
        check("rst_mul_a",     64'(mul_a),     64'd0);
        check("rst_mul_b",     64'(mul_b),     64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Zero-wait directed products.
        wait_cfg = 0;
        run_op(12'h001, 12'h219, 1'b0, 12'h219, "ident", 7, 6);
        run_op(12'h010, 12'h100, 1'b0, 12'h011, "reduce", 7, 6);
        check("reduce_seq_len", 64'(log_a.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < log_a.size()) check("reduce_seq_mul_a", 64'(log_a[i]), 64'(exp_seq[i]));
        end
        sq_chk = 1'b1;
        run_op(12'h010, 12'hAAA, 1'b1, 12'h100, "square", 7, 6);
        sq_chk = 1'b0;

        // Random ack delays with stray acks outside ISSUE.
        rnd_wait = 1'b1;
        stray_en = 1'b1;
        run_op(12'h004, 12'h004, 1'b0, 12'h002, "ws_zz", -1, -1);
        run_op(12'h100, 12'h100, 1'b0, 12'h110, "ws_y4", -1, -1);
        run_op(12'h011, 12'h011, 1'b0, 12'h121, "ws_1py_sq", -1, -1);
        run_op(12'h040, 12'h400, 1'b0, 12'h022, "ws_zy_zy2", -1, -1);
        run_op(12'h102, 12'h110, 1'b0, 12'h011, "ws_mix", -1, -1);
        sq_chk = 1'b1;
        run_op(12'h011, 12'hFFF, 1'b1, 12'h121, "ws_square", -1, -1);
        sq_chk   = 1'b0;
        rnd_wait = 1'b0;

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        run_op(12'h040, 12'h400, 1'b0, 12'h022, "bp", 7, 6);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_c",     64'(out_c),     64'h022);
            check("bp_in_ready",  64'(in_ready),  64'd0);
            check("bp_busy",      64'(busy),      64'd1);
            check("bp_out_valid", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_hs_out_valid", 64'(out_valid), 64'd0);
        check("bp_hs_in_ready",  64'(in_ready),  64'd1);
        check("bp_hs_busy",      64'(busy),      64'd0);
        stray_en = 1'b0;

        // Reset while product k=3 is pending.
        wait_cfg = 3;
        @(negedge clk);
        ack_count = 0;
        in_valid  = 1'b1;
        in_sq     = 1'b0;
        in_a      = 12'h102;
        in_b      = 12'h110;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (ack_count < 3 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #2;
        check("mid_k3_mul_req", 64'(mul_req), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_mul_req",   64'(mul_req),   64'd0);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy",      64'(busy),      64'd0);
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_mul_a", 64'(mul_a), 64'd0);
        reset = 1'b1;
        wait_cfg = 0;
        run_op(12'h102, 12'h110, 1'b0, 12'h011, "after_rst", 7, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
